// File: rtl/minterm_sweep_checker_if.sv
// Bus between minterm_sweep_checker (slave) and its controller / combinational DUT harness (master).
interface minterm_sweep_checker_if #(
  parameter int unsigned N_IN = 4
);
  logic                   start;
  logic [(2**N_IN)-1:0]   minterms;
  logic [N_IN-1:0]        dut_in;
  logic                   dut_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_fail;
  logic                   first_fail_vld;

  modport master (
    output start, minterms, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail, first_fail_vld
  );

  modport slave (
    input  start, minterms, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail, first_fail_vld
  );
endinterface

// File: rtl/minterm_sweep_checker.sv
// Clocked exhaustive truth-table checker: sweeps all 2^N_IN vectors and compares against a minterm mask.
// Optional: define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching minterm.
module minterm_sweep_checker #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  minterm_sweep_checker_if.slave  io_bus
);
  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned EW = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [NV-1:0]     r_mask;
  logic [CW-1:0]     r_cnt;
  logic [N_IN-1:0]   r_dut_in;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [EW-1:0]     r_err;
  logic [N_IN-1:0]   r_ff;
  logic              r_ffv;

  logic              w_sample;
  logic              w_mis;
  logic              w_last;
  logic              w_end;
  logic [EW-1:0]     w_err_nxt;

  assign w_sample  = (r_cnt == CNT_LAST);
  assign w_mis     = (io_bus.dut_out != r_mask[r_dut_in]);
  assign w_last    = (r_dut_in == LAST_VEC);
  assign w_err_nxt = r_err + EW'(w_mis);

  // Sweep termination: normally only after the last vector, optionally at the first mismatch.
`ifdef SWEEP_STOP_ON_FAIL_EN
  assign w_end = w_last | w_mis;
`else
  assign w_end = w_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_dut_in <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_ff     <= '0;
      r_ffv    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_mask   <= io_bus.minterms;
            r_err    <= '0;
            r_ff     <= '0;
            r_ffv    <= 1'b0;
            r_pass   <= 1'b0;
            r_dut_in <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (!w_sample) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            if (w_mis) begin
              r_err <= w_err_nxt;
              if (!r_ffv) begin
                r_ff  <= r_dut_in;
                r_ffv <= 1'b1;
              end
            end
            if (w_end) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= (w_err_nxt == '0);
              r_dut_in <= '0;
            end else begin
              r_dut_in <= r_dut_in + N_IN'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.dut_in         = r_dut_in;
  assign io_bus.busy           = r_busy;
  assign io_bus.done           = r_done;
  assign io_bus.pass           = r_pass;
  assign io_bus.err_count      = r_err;
  assign io_bus.first_fail     = r_ff;
  assign io_bus.first_fail_vld = r_ffv;
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Scoreboard bench for minterm_sweep_checker (N_IN=4, SETTLE=1, mask 16'hDF03).
module tb_minterm_sweep_checker;
  localparam int unsigned N_IN   = 4;
  localparam int unsigned SETTLE = 1;
  localparam int          WIN    = SETTLE + 1;
  localparam int          FULL   = 16 * WIN;

  typedef struct {
    logic       pass;
    logic [4:0] err;
    logic [3:0] ff;
    logic       ffv;
    int         done_cyc;
    int         e0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          mode;
  logic [15:0] model_mask = 16'hDF03;
  int          cyc = 0;
  int          cur_e0 = 0;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;
  int          trace_bad = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  minterm_sweep_checker_if #(.N_IN(N_IN)) bus ();

  minterm_sweep_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Behavioural DUT under test: golden, stuck-at-0, or golden with minterm 13 forced to 1.
  always_comb begin
    case (mode)
      1:       bus.dut_out = 1'b0;
      2:       bus.dut_out = (bus.dut_in == 4'd13) ? 1'b1 : model_mask[bus.dut_in];
      default: bus.dut_out = model_mask[bus.dut_in];
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: vector trace while busy, scoreboard compare on every done pulse.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        busy_cyc++;
        if (bus.dut_in !== 4'((cyc - cur_e0) / WIN)) trace_bad++;
      end
      if (bus.done) begin
        if (prev_done) check("done_pulse_width", 32'(bus.done), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("pass", 32'(bus.pass), 32'(e.pass));
          check("err_count", 32'(bus.err_count), 32'(e.err));
          check("first_fail", 32'(bus.first_fail), 32'(e.ff));
          check("first_fail_vld", 32'(bus.first_fail_vld), 32'(e.ffv));
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("busy_cycles", 32'(busy_cyc), 32'(e.done_cyc - e.e0));
          check("dut_in_trace_errors", 32'(trace_bad), 32'd0);
        end
        done_cnt++;
      end
      prev_done = bus.done;
    end
  end

  task automatic start_sweep(input int m, input logic [15:0] mt, input bit push,
                             input logic ep, input logic [4:0] eerr, input logic [3:0] eff,
                             input logic effv, input int lat);
    exp_t e;
    @(negedge clk);
    mode          = m;
    bus.minterms  = mt;
    bus.start     = 1'b1;
    cur_e0        = cyc + 1;
    busy_cyc      = 0;
    trace_bad     = 0;
    if (push) begin
      e.pass = ep; e.err = eerr; e.ff = eff; e.ffv = effv;
      e.e0 = cur_e0; e.done_cyc = cur_e0 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_dut_in", 32'(bus.dut_in), 32'd0);
    check("start_pass_cleared", 32'(bus.pass), 32'd0);
    check("start_err_cleared", 32'(bus.err_count), 32'd0);
    check("start_ffv_cleared", 32'(bus.first_fail_vld), 32'd0);
  endtask

  task automatic wait_done();
    int n0;
    bit got;
    n0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (done_cnt != n0);
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut_in"}, 32'(bus.dut_in), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    check({tag, "_first_fail"}, 32'(bus.first_fail), 32'd0);
    check({tag, "_first_fail_vld"}, 32'(bus.first_fail_vld), 32'd0);
  endtask

  initial begin
    int n0;
    rst          = 1'b1;
    mode         = 0;
    bus.start    = 1'b0;
    bus.minterms = 16'h0000;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Golden DUT: clean pass over all 16 vectors.
    start_sweep(0, 16'hDF03, 1'b1, 1'b1, 5'd0, 4'd0, 1'b0, FULL);
    wait_done();
    repeat (3) @(negedge clk);
    check("held_pass", 32'(bus.pass), 32'd1);
    check("held_busy", 32'(bus.busy), 32'd0);

    // Stuck-at-0 DUT.
`ifdef SWEEP_STOP_ON_FAIL_EN
    start_sweep(1, 16'hDF03, 1'b1, 1'b0, 5'd1, 4'd0, 1'b1, WIN);
`else
    start_sweep(1, 16'hDF03, 1'b1, 1'b0, 5'd9, 4'd0, 1'b1, FULL);
`endif
    wait_done();
    repeat (2) @(negedge clk);
    check("held_ffv", 32'(bus.first_fail_vld), 32'd1);

    // Single wrong minterm at 13.
`ifdef SWEEP_STOP_ON_FAIL_EN
    start_sweep(2, 16'hDF03, 1'b1, 1'b0, 5'd1, 4'd13, 1'b1, 14 * WIN);
`else
    start_sweep(2, 16'hDF03, 1'b1, 1'b0, 5'd1, 4'd13, 1'b1, FULL);
`endif
    wait_done();

    // A second start mid-sweep with a different mask must be ignored.
    start_sweep(0, 16'hDF03, 1'b1, 1'b1, 5'd0, 4'd0, 1'b0, FULL);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.minterms = 16'h0000;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done();

    // Reset at cycle 10 of a sweep: outputs clear, no done follows.
    start_sweep(0, 16'hDF03, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, FULL);
    repeat (9) @(negedge clk);
    n0  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midsweep_reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(n0));
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
